// File: rtl/div_operand_stage_pkg.sv
// Shared types and constants for the DIV operand stage.
// Occupancy state encoding and the divisor substituted for a captured zero.
package div_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam int DIV_DZ_SUBST = 1;

endpackage

// File: rtl/div_operand_stage_if.sv
// Operand handshake bundle between producer, operand stage and DIV consumer.
// master = producer/consumer side, slave = the operand stage itself.
interface div_operand_stage_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int DZ_CNT_WIDTH = 8
);

  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   in_a;
  logic [DATA_WIDTH-1:0]   in_b;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   out_a;
  logic [DATA_WIDTH-1:0]   out_b;
  logic                    out_dz;
  logic [DZ_CNT_WIDTH-1:0] dz_count;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_dz, dz_count
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_a, out_b, out_dz, dz_count
  );

endinterface

// File: rtl/div_operand_stage.sv
// Registered 2-entry skid buffer feeding the combinational divider, with divide-by-zero flagging.
// Optional DIV_ZERO_GUARD_EN: substitutes divisor 1 for 0 and enables out_dz and the saturating dz_count.
module div_operand_stage
  import div_stage_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int DZ_CNT_WIDTH = 8
) (
  input logic              Clk,
  input logic              Rst_n,
  div_operand_stage_if.slave bus
);

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] m_a;
  logic [DATA_WIDTH-1:0] m_b;
  logic                  m_dz;
  logic [DATA_WIDTH-1:0] s_a;
  logic [DATA_WIDTH-1:0] s_b;
  logic                  s_dz;
  logic                  in_fire;
  logic                  out_fire;
  logic [DATA_WIDTH-1:0] cap_b;
  logic                  cap_dz;
  logic                  load_m_in;
  logic                  load_m_skid;
  logic                  load_s;

  // Ready comes from state alone so there is no combinational path from out_ready.
  assign bus.in_ready  = (state != ST_FULL);
  assign bus.out_valid = (state != ST_EMPTY);
  assign in_fire       = bus.in_valid & bus.in_ready;
  assign out_fire      = bus.out_valid & bus.out_ready;

`ifdef DIV_ZERO_GUARD_EN
  assign cap_dz = (bus.in_b == '0);
  assign cap_b  = cap_dz ? DATA_WIDTH'(DIV_DZ_SUBST) : bus.in_b;
`else
  assign cap_dz = 1'b0;
  assign cap_b  = bus.in_b;
`endif

  always_comb begin
    state_nxt   = state;
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          load_m_in = 1'b1;
          state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        case ({in_fire, out_fire})
          2'b10: begin
            load_s    = 1'b1;
            state_nxt = ST_FULL;
          end
          2'b01:   state_nxt = ST_EMPTY;
          2'b11:   load_m_in = 1'b1;
          default: state_nxt = ST_ONE;
        endcase
      end
      ST_FULL: begin
        if (out_fire) begin
          load_m_skid = 1'b1;
          state_nxt   = ST_ONE;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Main register drives the divider; skid register only fills when the consumer stalls.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      m_a  <= '0;
      m_b  <= '0;
      m_dz <= 1'b0;
      s_a  <= '0;
      s_b  <= '0;
      s_dz <= 1'b0;
    end else begin
      if (load_m_in) begin
        m_a  <= bus.in_a;
        m_b  <= cap_b;
        m_dz <= cap_dz;
      end else if (load_m_skid) begin
        m_a  <= s_a;
        m_b  <= s_b;
        m_dz <= s_dz;
      end
      if (load_s) begin
        s_a  <= bus.in_a;
        s_b  <= cap_b;
        s_dz <= cap_dz;
      end
    end
  end

  assign bus.out_a  = m_a;
  assign bus.out_b  = m_b;
  assign bus.out_dz = m_dz;

`ifdef DIV_ZERO_GUARD_EN
  logic [DZ_CNT_WIDTH-1:0] dz_cnt;

  // Saturates at all-ones so a long stream of zero divisors never wraps back to a small count.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      dz_cnt <= '0;
    end else if (in_fire && cap_dz && (dz_cnt != '1)) begin
      dz_cnt <= dz_cnt + DZ_CNT_WIDTH'(1);
    end
  end

  assign bus.dz_count = dz_cnt;
`else
  assign bus.dz_count = {DZ_CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_div_operand_stage.sv
// Scoreboard bench for div_operand_stage: accepted pairs are queued from a reference model and popped as the DUT delivers them.
// Expected divisor/dz behaviour follows DIV_ZERO_GUARD_EN in the same way as the design.
module tb_div_operand_stage;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       dz;
  } pair_t;

  logic  clk;
  logic  rst_n;
  pair_t expq[$];
  int    model_dz;
  int    tests_run;
  int    tests_failed;

  div_operand_stage_if #(.DATA_WIDTH(8), .DZ_CNT_WIDTH(8)) bus ();

  div_operand_stage #(
    .DATA_WIDTH  (8),
    .DZ_CNT_WIDTH(8)
  ) dut (
    .Clk  (clk),
    .Rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: a zero divisor becomes 1 and is flagged only when the guard is built in.
  function automatic pair_t refPair(input logic [7:0] a, input logic [7:0] b);
    pair_t r;
    r.a = a;
`ifdef DIV_ZERO_GUARD_EN
    r.b  = (b == 8'd0) ? 8'd1 : b;
    r.dz = (b == 8'd0);
`else
    r.b  = b;
    r.dz = 1'b0;
`endif
    return r;
  endfunction

  // Monitor: the queue holds exactly the pairs inside the stage, so occupancy and data follow from it.
  always @(negedge clk) begin
    checkOutput("out_valid", 32'(bus.out_valid), 32'(expq.size() > 0));
    checkOutput("in_ready", 32'(bus.in_ready), 32'(expq.size() < 2));
    checkOutput("dz_count", 32'(bus.dz_count), 32'(model_dz));
    if (bus.out_valid && expq.size() > 0) begin
      checkOutput("out_a", 32'(bus.out_a), 32'(expq[0].a));
      checkOutput("out_b", 32'(bus.out_b), 32'(expq[0].b));
      checkOutput("out_dz", 32'(bus.out_dz), 32'(expq[0].dz));
    end
    if (!rst_n) begin
      expq.delete();
      model_dz = 0;
    end else begin
      if (bus.out_valid && bus.out_ready && expq.size() > 0) begin
        void'(expq.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(refPair(bus.in_a, bus.in_b));
`ifdef DIV_ZERO_GUARD_EN
        if (bus.in_b == 8'd0 && model_dz < 255) model_dz++;
`endif
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    logic accepted;
    accepted     = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    for (int i = 0; i < 100; i++) begin
      accepted = bus.in_ready;
      @(posedge clk);
      #1;
      if (accepted) break;
    end
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (expq.size() == 0) break;
      @(posedge clk);
      #1;
    end
    checkOutput("drain_left", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    model_dz      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'hAA;
    bus.in_b      = 8'h00;
    bus.out_ready = 1'b0;

    // Reset held two edges with in_valid high: nothing captured, outputs zero.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_a", 32'(bus.out_a), 32'd0);
    checkOutput("rst_out_b", 32'(bus.out_b), 32'd0);
    checkOutput("rst_dz_count", 32'(bus.dz_count), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back streaming.
    bus.out_ready = 1'b1;
    applyStimulus(8'd100, 8'd7);
    applyStimulus(8'd9, 8'd3);
    applyStimulus(8'd255, 8'd16);
    drain();

    // Backpressure fills the skid register, then releases in order.
    bus.out_ready = 1'b0;
    applyStimulus(8'd50, 8'd5);
    applyStimulus(8'd60, 8'd6);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    drain();

    // Divide-by-zero, then enough zero pairs to saturate the counter.
    applyStimulus(8'd42, 8'd0);
    drain();
    for (int i = 0; i < 300; i++) applyStimulus(8'(i), 8'd0);
    drain();
    checkOutput("dz_sat", 32'(bus.dz_count), 32'(model_dz));

    // Reset while FULL drops both pairs.
    bus.out_ready = 1'b0;
    applyStimulus(8'd1, 8'd1);
    applyStimulus(8'd2, 8'd2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    applyStimulus(8'd8, 8'd2);
    drain();

    // Randomized traffic with random backpressure and frequent zero divisors.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom % 4) != 0;
      bus.in_a      = 8'($urandom);
      bus.in_b      = (($urandom % 4) == 0) ? 8'd0 : 8'($urandom);
      bus.out_ready = ($urandom % 3) != 0;
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
